// File: rtl/complex_div.sv
// complex_div: sequential complex divider Q = A / B = A*conj(B) / |B|^2.
// One shared 8x8 signed multiplier forms the six partial products, then two
// restoring dividers (real and imaginary) run side by side, one quotient bit
// per cycle. Results are Q9.FRAC signed, truncated toward zero.
//
// Handshake: start is sampled only while idle (busy=0). done is a one-cycle
// pulse; qr/qi/div_zero become valid with it and hold until the next done or
// reset. start while busy is ignored; ar/ai/br/bi may change once start has
// been sampled.
module complex_div #(
  parameter int FRAC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        ar,
  input  logic [7:0]        ai,
  input  logic [7:0]        br,
  input  logic [7:0]        bi,
  output logic [8+FRAC:0]   qr,
  output logic [8+FRAC:0]   qi,
  output logic              busy,
  output logic              done,
  output logic              div_zero
);

  localparam int QW = 9 + FRAC;     // result width
  localparam int DW = 16 + FRAC;    // dividend / quotient width
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t state, state_nxt;

  // Latched operands
  logic signed [7:0]  ar_r, ai_r, br_r, bi_r;
  // MUL phase
  logic [2:0]         step;
  logic signed [16:0] nr_acc, ni_acc;
  logic [15:0]        d_acc;
  logic               zero_r;
  // DIV phase
  logic               sr, si;
  logic [15:0]        rem_r, rem_i;
  logic [DW-1:0]      dd_r, dd_i;   // dividend shifts out, quotient shifts in
  logic [CW-1:0]      cnt;

  // Shared multiplier and helpers
  logic signed [7:0]  mul_a, mul_b;
  logic signed [15:0] prod;
  logic [15:0]        d_fin;
  logic [15:0]        nr_mag, ni_mag;
  logic [16:0]        trial_r, trial_i;
  logic               ge_r, ge_i;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (br == 8'd0 && bi == 8'd0) ? FIN : MUL;
      MUL:  if (step == 3'd5) state_nxt = DIV;
      DIV:  if (cnt == '0) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand select for the single multiplier, plus divider trial subtracts
  always_comb begin
    mul_a = ar_r;
    mul_b = br_r;
    case (step)
      3'd0: begin mul_a = ar_r; mul_b = br_r; end
      3'd1: begin mul_a = ai_r; mul_b = bi_r; end
      3'd2: begin mul_a = ai_r; mul_b = br_r; end
      3'd3: begin mul_a = ar_r; mul_b = bi_r; end
      3'd4: begin mul_a = br_r; mul_b = br_r; end
      3'd5: begin mul_a = bi_r; mul_b = bi_r; end
      default: begin mul_a = ar_r; mul_b = br_r; end
    endcase
    prod    = mul_a * mul_b;
    // Squares are non-negative, so the product bits add as unsigned.
    d_fin   = d_acc + prod;
    nr_mag  = nr_acc[16] ? 16'(-nr_acc) : nr_acc[15:0];
    ni_mag  = ni_acc[16] ? 16'(-ni_acc) : ni_acc[15:0];
    trial_r = {rem_r, dd_r[DW-1]};
    trial_i = {rem_i, dd_i[DW-1]};
    ge_r    = trial_r >= {1'b0, d_acc};
    ge_i    = trial_i >= {1'b0, d_acc};
  end

  // Datapath and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      qr       <= '0;
      qi       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      ar_r     <= '0;
      ai_r     <= '0;
      br_r     <= '0;
      bi_r     <= '0;
      step     <= '0;
      nr_acc   <= '0;
      ni_acc   <= '0;
      d_acc    <= '0;
      zero_r   <= 1'b0;
      sr       <= 1'b0;
      si       <= 1'b0;
      rem_r    <= '0;
      rem_i    <= '0;
      dd_r     <= '0;
      dd_i     <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ar_r   <= ar;
            ai_r   <= ai;
            br_r   <= br;
            bi_r   <= bi;
            busy   <= 1'b1;
            step   <= '0;
            nr_acc <= '0;
            ni_acc <= '0;
            d_acc  <= '0;
            zero_r <= (br == 8'd0 && bi == 8'd0);
          end
        end
        MUL: begin
          step <= step + 3'd1;
          case (step)
            3'd0, 3'd1: nr_acc <= nr_acc + 17'(prod);
            3'd2:       ni_acc <= ni_acc + 17'(prod);
            3'd3:       ni_acc <= ni_acc - 17'(prod);
            3'd4:       d_acc  <= d_fin;
            default: begin
              // Last product: D is complete, Nr/Ni already are, so the
              // divider is loaded with signs and magnitudes right here.
              d_acc <= d_fin;
              sr    <= nr_acc[16];
              si    <= ni_acc[16];
              rem_r <= '0;
              rem_i <= '0;
              dd_r  <= {nr_mag, {FRAC{1'b0}}};
              dd_i  <= {ni_mag, {FRAC{1'b0}}};
              cnt   <= CW'(DW - 1);
            end
          endcase
        end
        DIV: begin
          cnt   <= cnt - 1'b1;
          rem_r <= ge_r ? 16'(trial_r - {1'b0, d_acc}) : trial_r[15:0];
          rem_i <= ge_i ? 16'(trial_i - {1'b0, d_acc}) : trial_i[15:0];
          dd_r  <= {dd_r[DW-2:0], ge_r};
          dd_i  <= {dd_i[DW-2:0], ge_i};
        end
        FIN: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          div_zero <= zero_r;
          if (zero_r) begin
            qr <= '0;
            qi <= '0;
          end else begin
            qr <= sr ? -dd_r[QW-1:0] : dd_r[QW-1:0];
            qi <= si ? -dd_i[QW-1:0] : dd_i[QW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_div.sv
// tb_complex_div: random and directed checks of complex_div against a plain
// integer-arithmetic model of Q = A / B truncated toward zero.
module tb_complex_div;

  localparam int FRAC = 8;
  localparam int QW   = 9 + FRAC;
  localparam int EW   = 1 + 2 * QW;     // {div_zero, qr, qi}
  localparam int LAT_NORM = 24 + FRAC;  // edges, start sample to done, inclusive
  localparam int LAT_ZERO = 2;

  logic          clk, rst, start;
  logic [7:0]    ar, ai, br, bi;
  logic [QW-1:0] qr, qi;
  logic          busy, done, div_zero;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [EW-1:0] exp_q[$];

  complex_div #(.FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ar(ar), .ai(ai), .br(br), .bi(bi),
    .qr(qr), .qi(qi), .busy(busy), .done(done), .div_zero(div_zero)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input longint act, input longint req);
    n_compared++;
    if (act != req) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic longint sfield(input logic [QW-1:0] v);
    logic signed [QW-1:0] s;
    s = v;
    return longint'(s);
  endfunction

  // Reference: exact integer arithmetic, SV division truncates toward zero.
  function automatic logic [EW-1:0] model(input int a_r, input int a_i,
                                          input int b_r, input int b_i);
    longint nr, ni, d, q_r, q_i;
    nr = a_r * b_r + a_i * b_i;
    ni = a_i * b_r - a_r * b_i;
    d  = b_r * b_r + b_i * b_i;
    if (d == 0) return {1'b1, {QW{1'b0}}, {QW{1'b0}}};
    q_r = (nr * (longint'(1) << FRAC)) / d;
    q_i = (ni * (longint'(1) << FRAC)) / d;
    return {1'b0, QW'(q_r), QW'(q_i)};
  endfunction

  task automatic pin(input string name, input int a_r, input int a_i,
                     input int b_r, input int b_i,
                     input longint e_r, input longint e_i, input longint e_z);
    logic [EW-1:0] m;
    m = model(a_r, a_i, b_r, b_i);
    check({name, "_model_qr"}, sfield(m[2*QW-1:QW]), e_r);
    check({name, "_model_qi"}, sfield(m[QW-1:0]), e_i);
    check({name, "_model_dz"}, longint'(m[EW-1]), e_z);
  endtask

  // Compare process: every done pulse is checked against the oldest expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("qr", sfield(qr), sfield(e[2*QW-1:QW]));
        check("qi", sfield(qi), sfield(e[QW-1:0]));
        check("div_zero", longint'(div_zero), longint'(e[EW-1]));
      end
    end
  end

  // Driver: called at #1 after an edge; runs one operation to its done pulse.
  // poke_at > 0 re-pulses start with other operands that many edges in.
  task automatic run_op(input int a_r, input int a_i, input int b_r, input int b_i,
                        input int poke_at);
    int n, lat;
    exp_q.push_back(model(a_r, a_i, b_r, b_i));
    lat = (b_r == 0 && b_i == 0) ? LAT_ZERO : LAT_NORM;
    ar = 8'(a_r); ai = 8'(a_i); br = 8'(b_r); bi = 8'(b_i);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    check("busy_after_start", longint'(busy), 1);
    // Operands are free to change once sampled.
    ar = 8'($urandom_range(0, 255)); ai = 8'($urandom_range(0, 255));
    br = 8'($urandom_range(1, 255)); bi = 8'($urandom_range(0, 255));
    while (!done && n < 200) begin
      if (n == poke_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (!done) check("busy_while_running", longint'(busy), 1);
    end
    check("latency_edges", n, lat);
    check("busy_at_done", longint'(busy), 0);
  endtask

  task automatic rand_op();
    int a_r, a_i, b_r, b_i;
    a_r = int'($urandom_range(0, 255)) - 128;
    a_i = int'($urandom_range(0, 255)) - 128;
    if ($urandom_range(0, 7) == 0) begin
      b_r = 0; b_i = 0;
    end else begin
      b_r = int'($urandom_range(0, 255)) - 128;
      b_i = int'($urandom_range(0, 255)) - 128;
      if (b_r == 0 && b_i == 0) b_r = 1;
    end
    run_op(a_r, a_i, b_r, b_i, 0);
  endtask

  // Main sequence
  initial begin
    rst = 1'b1; start = 1'b0;
    ar = '0; ai = '0; br = '0; bi = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_qr", sfield(qr), 0);
    check("reset_qi", sfield(qi), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done), 0);
    check("reset_div_zero", longint'(div_zero), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Hand-computed values that pin the model
    pin("a10_5_b1_0",   10,   5,  1, 0,  2560,  1280, 0);
    pin("a1_0_bj",       1,   0,  0, 1,     0,  -256, 0);
    pin("a1_1_b1_1",     1,   1,  1, 1,   256,     0, 0);
    pin("third",         1,   0,  3, 0,    85,     0, 0);
    pin("neg_third",    -1,   0,  3, 0,   -85,     0, 0);
    pin("max_pos",    -128,-128, -1, 0, 32768, 32768, 0);
    pin("max_neg",    -128,   0,  1, 0,-32768,     0, 0);
    pin("b_zero",        7,   7,  0, 0,     0,     0, 1);

    // Directed operations, chained back to back
    run_op(10, 5, 1, 0, 0);
    run_op(1, 0, 0, 1, 0);
    run_op(1, 1, 1, 1, 0);
    run_op(1, 0, 3, 0, 0);
    run_op(-1, 0, 3, 0, 0);
    run_op(-128, -128, -1, 0, 0);
    run_op(-128, 0, 1, 0, 0);
    run_op(7, 7, 0, 0, 0);
    run_op(3, -2, 5, 7, 0);            // clears div_zero again
    run_op(100, -50, -3, 9, 12);       // start re-pulsed mid-DIV

    // Reset during MUL aborts with no done
    exp_q.push_back(model(20, 20, 2, 2));
    ar = 8'd20; ai = 8'd20; br = 8'd2; bi = 8'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", longint'(busy), 0);
    check("abort_done", longint'(done), 0);
    exp_q.delete();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_op(-77, 33, 12, -5, 0);

    // Random traffic
    for (int i = 0; i < 40; i++) rand_op();

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
